fwd_hazard_unit: RTL

- Parametrised forwarding and hazard unit for the pipelined MIPS datapath.
- Generalises the ALU-operand and store-data forwarding selects to FWD_DEPTH younger pipeline stages.
- Adds sequential load-use stall control: stall FSM with a multi-cycle countdown, plus a pipeline freeze for a slow data memory.
- Adds saturating performance counters.
- Sits beside the ID stage; its selects and controls drive the ID/EX operand muxes, PC/IF-ID hold and ID/EX bubble insertion.

---
 rtl/fwd_hazard_unit.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use hazard controller for the pipelined MIPS datapath.
// Generates operand/store forward selects, stall/bubble/freeze control and saturating event counters.
//
// state  | meaning
// -------+--------------------------------------------------------------
// RUN    | normal issue; stalls only on a load-use hazard seen this cycle
// LSTALL | multi-cycle load-use stall; cnt holds remaining stall cycles
module fwd_hazard_unit #(
    parameter int RA_W       = 5,
    parameter int FWD_DEPTH  = 3,
    parameter int LOAD_AVAIL = 1,
    parameter int MEM_STAGE  = 1,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = $clog2(FWD_DEPTH + 2)
) (
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic                      UseShamt,
    input  logic                      UseImmed,
    input  logic [RA_W-1:0]           ID_Rs,
    input  logic [RA_W-1:0]           ID_Rt,
    input  logic                      ID_IsStore,
    input  logic [FWD_DEPTH*RA_W-1:0] Stg_Rw,
    input  logic [FWD_DEPTH-1:0]      Stg_RegWrite,
    input  logic [FWD_DEPTH-1:0]      Stg_MemRead,
    input  logic                      MemReady,
    input  logic                      CntClr,
    output logic [SEL_W-1:0]          AluOpCtrlA,
    output logic [SEL_W-1:0]          AluOpCtrlB,
    output logic [SEL_W-1:0]          StoreFwdSel,
    output logic                      Stall,
    output logic                      Bubble,
    output logic                      Freeze,
    output logic [CNT_W-1:0]          StallCycles,
    output logic [CNT_W-1:0]          FwdEvents
);

    localparam int CW = $clog2(FWD_DEPTH + 1);

    typedef enum logic {RUN, LSTALL} stateType;

    stateType        state, nextState;
    logic [CW-1:0]   cnt, nextCnt;

    logic            rsFound, rtFound, rsLoad, rtLoad;
    logic [CW-1:0]   rsIdx, rtIdx;
    logic            rsHaz, rtHaz, hazard;
    logic [CW-1:0]   hazIdx, hazN;
    logic            stallRaw, anyFwd;

    function automatic logic [SEL_W-1:0] encSel(input logic found, input logic [CW-1:0] idx);
        return found ? SEL_W'(FWD_DEPTH - int'(idx)) : SEL_W'(FWD_DEPTH + 1);
    endfunction

    function automatic logic isStage(input logic [SEL_W-1:0] s);
        return (s != '0) && (s <= SEL_W'(FWD_DEPTH));
    endfunction

    // Scan oldest to youngest so the youngest matching stage overwrites older ones.
    always_comb begin
        rsFound = 1'b0;
        rtFound = 1'b0;
        rsLoad  = 1'b0;
        rtLoad  = 1'b0;
        rsIdx   = '0;
        rtIdx   = '0;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (Stg_RegWrite[k] && (Stg_Rw[k*RA_W +: RA_W] != '0)) begin
                if (Stg_Rw[k*RA_W +: RA_W] == ID_Rs) begin
                    rsFound = 1'b1;
                    rsIdx   = CW'(k);
                    rsLoad  = Stg_MemRead[k];
                end
                if (Stg_Rw[k*RA_W +: RA_W] == ID_Rt) begin
                    rtFound = 1'b1;
                    rtIdx   = CW'(k);
                    rtLoad  = Stg_MemRead[k];
                end
            end
        end
    end

    assign AluOpCtrlA  = UseShamt   ? '0 : encSel(rsFound, rsIdx);
    assign AluOpCtrlB  = UseImmed   ? '0 : encSel(rtFound, rtIdx);
    assign StoreFwdSel = ID_IsStore ? encSel(rtFound, rtIdx) : SEL_W'(FWD_DEPTH + 1);

    // rt only matters for hazards when it feeds the ALU; pure store data is not checked.
    assign rsHaz  = !UseShamt && rsFound && rsLoad && (rsIdx < CW'(LOAD_AVAIL));
    assign rtHaz  = !UseImmed && rtFound && rtLoad && (rtIdx < CW'(LOAD_AVAIL));
    assign hazard = rsHaz || rtHaz;

    always_comb begin
        hazIdx = '0;
        if (rsHaz && rtHaz)
            hazIdx = (rsIdx < rtIdx) ? rsIdx : rtIdx;
        else if (rsHaz)
            hazIdx = rsIdx;
        else if (rtHaz)
            hazIdx = rtIdx;
    end

    assign hazN   = CW'(LOAD_AVAIL) - hazIdx;
    assign Freeze = Stg_MemRead[MEM_STAGE] && !MemReady;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
        end
    end

    always_comb begin
        nextState = state;
        nextCnt   = cnt;
        stallRaw  = 1'b0;
        case (state)
            RUN: begin
                if (hazard) begin
                    stallRaw = 1'b1;
                    if ((hazN > CW'(1)) && !Freeze) begin
                        nextState = LSTALL;
                        nextCnt   = hazN - CW'(1);
                    end
                end
            end
            LSTALL: begin
                stallRaw = 1'b1;
                if (!Freeze) begin
                    if (cnt == CW'(1)) begin
                        nextState = RUN;
                        nextCnt   = '0;
                    end else begin
                        nextCnt = cnt - CW'(1);
                    end
                end
            end
            default: begin
                nextState = RUN;
                nextCnt   = '0;
            end
        endcase
    end

    // Reset must silence Stall even while a hazard is present on the stage inputs.
    assign Stall  = stallRaw && !Reset;
    assign Bubble = Stall && !Freeze;
    assign anyFwd = isStage(AluOpCtrlA) || isStage(AluOpCtrlB) || isStage(StoreFwdSel);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            StallCycles <= '0;
            FwdEvents   <= '0;
        end else if (CntClr) begin
            StallCycles <= '0;
            FwdEvents   <= '0;
        end else begin
            if ((Stall || Freeze) && (StallCycles != '1))
                StallCycles <= StallCycles + CNT_W'(1);
            if (!Stall && !Freeze && anyFwd && (FwdEvents != '1))
                FwdEvents <= FwdEvents + CNT_W'(1);
        end
    end

endmodule
